// File: rtl/mem_bus_pkg.sv
// Shared definitions for the SoC valid/ready memory bus: strobes, address map,
// request payload and the copy-engine state encoding.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [STRB_W-1:0] WSTRB_WORD = 4'b1111;
    localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;

    localparam logic [ADDR_W-1:0] BRAM_LIMIT = 32'd8192;
    localparam logic [ADDR_W-1:0] UART_DATA  = 32'hF000_0000;
    localparam logic [ADDR_W-1:0] UART_CTL   = 32'hF000_0004;
    localparam logic [ADDR_W-1:0] LED_CTL    = 32'hF000_1000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_e;

endpackage

// File: rtl/mem_copy_master.sv
// Word-copy bus initiator: reads len words from src and writes them to dst.
// Optional per-transaction ready timeout enabled by MEM_COPY_TIMEOUT_EN.
module mem_copy_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_valid,
    output logic              mem_instr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    mem_req_t          req_q, req_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              to_hit_c;

`ifdef MEM_COPY_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counter restarts whenever mem_valid is low, so it measures the current request only
    always_comb begin
        to_cnt_d = '0;
        if (valid_q) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign to_hit_c = valid_q && !mem_ready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign to_hit_c       = 1'b0;
`endif

    // Every request is entered from a cycle with mem_valid low, giving the mandatory idle gap
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        req_d   = req_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        error_d = error_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr & WORD_MASK;
                    dst_d   = dst_addr & WORD_MASK;
                    len_d   = len_words;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d     = RD;
                        valid_d     = 1'b1;
                        req_d.addr  = src_addr & WORD_MASK;
                        req_d.wstrb = WSTRB_READ;
                    end
                end
            end
            RD: begin
                if (!valid_q) begin
                    if (len_q == '0) begin
                        state_d = FIN;
                    end else begin
                        valid_d     = 1'b1;
                        req_d.addr  = src_q;
                        req_d.wstrb = WSTRB_READ;
                    end
                end else if (mem_ready) begin
                    data_d  = mem_rdata;
                    valid_d = 1'b0;
                    state_d = WR;
                end
            end
            WR: begin
                if (!valid_q) begin
                    valid_d     = 1'b1;
                    req_d.addr  = dst_q;
                    req_d.wdata = data_q;
                    req_d.wstrb = WSTRB_WORD;
                end else if (mem_ready) begin
                    valid_d = 1'b0;
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    len_d   = len_q - LEN_W'(1);
                    state_d = RD;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (to_hit_c) begin
            valid_d = 1'b0;
            error_d = 1'b1;
            state_d = FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_valid = valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: a BRAM-like responder answers the bus,
// expected transactions and done events are queued and checked by a monitor.
module tb_mem_copy_master;
    import mem_bus_pkg::*;

    typedef struct {
        int unsigned cyc;
        int unsigned busy_cycles;
    } done_exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy, done, error;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_copy_master #(.LEN_W(16), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    logic [31:0]  mem [0:1023];
    mem_req_t     exp_q[$];
    done_exp_t    done_q[$];
    int unsigned  total = 0;
    int unsigned  bad = 0;
    int unsigned  cyc = 0;
    int unsigned  ready_delay = 0;
    int unsigned  done_cnt = 0;
    int unsigned  c0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{addr: a, wdata: 32'h0, wstrb: WSTRB_READ});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, wdata: d, wstrb: WSTRB_WORD});
    endtask

    task automatic push_done(input int unsigned rel, input int unsigned bcy);
        done_q.push_back('{cyc: c0 + rel, busy_cycles: bcy});
    endtask

    // Start is raised for exactly one cycle, recorded as relative cycle 0
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len_words = l;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL done_timeout: got done_cnt %0d expected %0d", done_cnt, target);
        end
    endtask

    // Responder: ready after ready_delay wait cycles; writes land in mem, rdata is junk when not ready
    initial begin
        int unsigned wait_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'hF) mem[mem_addr[11:2]] = mem_wdata;
                    else mem_rdata = mem[mem_addr[11:2]];
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: handshakes against exp_q, request stability during waits, done events against done_q
    initial begin
        mem_req_t    e;
        mem_req_t    prev;
        logic        prev_wait = 1'b0;
        int unsigned busy_cycles = 0;
        done_exp_t   de;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_wait   = 1'b0;
                busy_cycles = 0;
            end else begin
                if (mem_valid) begin
                    if (prev_wait) begin
                        chk("hold_addr", mem_addr, prev.addr);
                        chk("hold_wdata", mem_wdata, prev.wdata);
                        chk("hold_wstrb", 32'(mem_wstrb), 32'(prev.wstrb));
                    end
                    if (mem_ready) begin
                        prev_wait = 1'b0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_txn: got addr %h wstrb %h expected none", mem_addr, mem_wstrb);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txn_addr", mem_addr, e.addr);
                            chk("txn_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                            chk("txn_instr", 32'(mem_instr), 32'h0);
                            if (e.wstrb == WSTRB_WORD) chk("txn_wdata", mem_wdata, e.wdata);
                        end
                    end else begin
                        prev_wait = 1'b1;
                        prev      = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
                    end
                end else begin
                    prev_wait = 1'b0;
                end
                if (busy) busy_cycles++;
                if (done) begin
                    done_cnt++;
                    chk("done_busy_low", 32'(busy), 32'h0);
                    chk("done_error", 32'(error), 32'h0);
                    if (done_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        de = done_q.pop_front();
                        chk("done_cycle", cyc, de.cyc);
                        chk("busy_cycles", busy_cycles, de.busy_cycles);
                    end
                    busy_cycles = 0;
                end
            end
        end
    end

    initial begin
        int unsigned n;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_valid", 32'(mem_valid), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_instr", 32'(mem_instr), 32'h0);
        reset = 1'b0;

        // Four-word copy with zero-wait responder
        ready_delay = 0;
        push_rd(32'h0);  push_wr(32'h100, 32'h11);
        push_rd(32'h4);  push_wr(32'h104, 32'h22);
        push_rd(32'h8);  push_wr(32'h108, 32'h33);
        push_rd(32'hC);  push_wr(32'h10C, 32'h44);
        do_start(32'h0, 32'h100, 16'd4);
        push_done(18, 17);
        wait_done(1);
        chk("mem_100", mem[64], 32'h11);
        chk("mem_10c", mem[67], 32'h44);

        // Three wait cycles per transaction; a start while busy must be ignored
        ready_delay = 3;
        push_rd(32'h8);  push_wr(32'h180, 32'h33);
        push_rd(32'hC);  push_wr(32'h184, 32'h44);
        do_start(32'h8, 32'h180, 16'd2);
        push_done(22, 21);
        repeat (3) @(negedge clk);
        start = 1'b1; src_addr = 32'h40; dst_addr = 32'h500; len_words = 16'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        chk("mem_184", mem[97], 32'h44);
        chk("mem_500_untouched", mem[320], 32'hA000_0140);

        // Zero-length copy: no bus traffic, done two cycles after start
        ready_delay = 0;
        do_start(32'h20, 32'h600, 16'd0);
        push_done(2, 1);
        wait_done(3);

        // Source address wraps past the top of the address space
        push_rd(32'hFFFF_FFFC); push_wr(32'h300, 32'hA000_03FF);
        push_rd(32'h0);         push_wr(32'h304, 32'h11);
        do_start(32'hFFFF_FFFC, 32'h300, 16'd2);
        push_done(10, 9);
        wait_done(4);

        // Unaligned addresses are issued word-aligned
        push_rd(32'h100); push_wr(32'h400, 32'h11);
        do_start(32'h103, 32'h401, 16'd1);
        push_done(6, 5);
        wait_done(5);
        chk("mem_400", mem[256], 32'h11);

        // Reset during the second write: valid drops next cycle, no done, first word stays copied
        ready_delay = 3;
        push_rd(32'h10); push_wr(32'h200, 32'hA000_0004);
        push_rd(32'h14);
        do_start(32'h10, 32'h200, 16'd3);
        n = 0;
        while (!(mem_valid && mem_wstrb == 4'hF && mem_addr == 32'h204) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("second_wr_reached", 32'(mem_addr), 32'h204);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(mem_valid), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("partial_word0", mem[128], 32'hA000_0004);
        chk("partial_word1", mem[129], 32'hA000_0081);
        chk("partial_exp_left", exp_q.size(), 32'h0);

        // Copy after the aborted transfer
        ready_delay = 0;
        push_rd(32'h0); push_wr(32'h280, 32'h11);
        push_rd(32'h4); push_wr(32'h284, 32'h22);
        do_start(32'h0, 32'h280, 16'd2);
        push_done(10, 9);
        wait_done(6);
        chk("mem_284", mem[161], 32'h22);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 32'h0);
        chk("done_q_empty", done_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
